fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
- Owns the single write port of the VGA framebuffer (40x30 cells, 3-bit RGB, default scaling 16) and shares it between two requesters.
- Requester 1 is CPU single-pixel stores, decoded from the memory-mapped video region, using a valid/ready handshake.
- Requester 2 is a hardware rectangle-fill engine, used for clear-screen and solid boxes, started by a command pulse.
- Emits registered we/addr/data straight into the framebuffer write port and arbitrates round-robin when both requesters contend.

Parameters:
- FB_WIDTH, 40, framebuffer columns.
- FB_HEIGHT, 30, framebuffer rows.
- ADDR_WIDTH, 11, framebuffer address width; must be >= $clog2(FB_WIDTH*FB_HEIGHT).
- Derived (localparam): XW = $clog2(FB_WIDTH) = 6; YW = $clog2(FB_HEIGHT) = 5.

Ports:
- clock  in  1  system clock; the same clock as the framebuffer write port.
- resetn  in  1  asynchronous active-low reset.
- px_valid  in  1  CPU pixel write request.
- px_ready  out  1  CPU request accepted this cycle.
- px_x  in  XW  pixel column.
- px_y  in  YW  pixel row.
- px_color  in  3  pixel RGB.
- fill_start  in  1  single-cycle fill command.
- fill_x0  in  XW  rectangle left edge.
- fill_y0  in  YW  rectangle top edge.
- fill_w  in  XW+1  rectangle width in cells.
- fill_h  in  YW+1  rectangle height in cells.
- fill_color  in  3  fill RGB.
- fill_busy  out  1  fill engine not idle.
- fill_done  out  1  one-cycle pulse when a fill completes.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  ADDR_WIDTH  framebuffer write address.
- fb_data  out  3  framebuffer write data.

Behaviour:
- Reset (asynchronous, any state, including mid-fill):
  - fb_we=0, fb_addr=0, fb_data=0, fill_busy=0, fill_done=0.
  - FSM returns to IDLE, last_grant=FILL, all latched fill registers cleared.
  - No further writes from an aborted fill.
- Address: fb_addr = y*FB_WIDTH + x, computed at full width, then truncated to ADDR_WIDTH.
- Outputs are registered: a write granted in cycle N appears on fb_we/fb_addr/fb_data in cycle N+1 for exactly one cycle. When there is no grant, fb_we=0 and addr/data hold their previous values.
- FSM states:
  - IDLE -> FILL on fill_start. Latches x0, y0, color, x_end = min(x0+w, FB_WIDTH), y_end = min(y0+h, FB_HEIGHT); cursor cx=x0, cy=y0.
  - IDLE -> DONE on fill_start if w==0, h==0, x0>=FB_WIDTH or y0>=FB_HEIGHT. No writes are issued.
  - FILL -> DONE after the write at (x_end-1, y_end-1) is granted.
  - DONE -> IDLE unconditionally after one cycle.
- fill_busy = (state != IDLE); it asserts the cycle after fill_start. fill_done = (state == DONE).
- fill_start outside IDLE is ignored; the latched parameters are not disturbed.
- Fill cursor, advanced only on cycles the fill wins the port:
  - cx <= cx+1.
  - When cx == x_end-1: cx <= x0, cy <= cy+1.
  - Raster order, left-to-right then top-to-bottom.
- Arbitration (combinational grant each cycle):
  - Only px_valid: CPU granted.
  - Only FILL state: fill granted.
  - Both: grant the requester that did not win the last contested cycle. last_grant updates only on contested cycles. After reset the CPU wins the first contest.
  - px_ready = px_valid && CPU granted. The CPU must hold px_x/px_y/px_color stable while px_valid && !px_ready.
- Out-of-range CPU pixel (px_x >= FB_WIDTH or px_y >= FB_HEIGHT):
  - The handshake completes normally (px_ready asserted per arbitration).
  - fb_we stays 0 for that slot. The slot still counts as a CPU grant for round-robin.
- fill_start and px_valid in the same IDLE cycle: the CPU is served that cycle and the fill begins next cycle.
- Worst-case fill throughput under continuous CPU traffic: 1 write per 2 cycles. Without contention: 1 write per cycle.
- Full-screen clear (0,0,40,30) with no CPU traffic:
  - 1200 consecutive writes, addresses 0..1199.
  - fill_done is asserted 1 cycle after the state leaves FILL.

Test Plan:
- Reset, then px_valid with (x=3, y=2, color=5) -> px_ready same cycle; next cycle fb_we=1, fb_addr=83, fb_data=5; then fb_we=0.
- fill_start (0,0,40,30, color=2), no CPU traffic -> 1200 consecutive fb_we cycles, addresses 0..1199 in order, data 2; fill_done pulses once; fill_busy falls with it.
- Fill (38,28,5,5, color=7) -> clipped to 4 writes at addresses 1158, 1159, 1198, 1199; then fill_done.
- Fill (10,10,3,1) with px_valid held high throughout -> grants alternate CPU, fill, CPU, fill...; fill addresses 410, 411, 412 interleaved; fill_done after the 3rd fill write.
- px_valid with x=45 -> px_ready=1, no fb_we pulse. Fill with w=0 -> fill_busy 1 cycle, fill_done 1 cycle, zero writes.
- Assert resetn=0 midway through a full-screen fill -> outputs zero immediately; after release, no fb_we without a new request; fill_busy=0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Single write port of the VGA framebuffer, shared round-robin between CPU pixel
// stores and a rectangle-fill engine; all port outputs are registered.
module fb_write_arbiter #(
    parameter int FB_WIDTH   = 40,
    parameter int FB_HEIGHT  = 30,
    parameter int ADDR_WIDTH = 11,
    localparam int XW = $clog2(FB_WIDTH),
    localparam int YW = $clog2(FB_HEIGHT)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [XW-1:0]         px_x,
    input  logic [YW-1:0]         px_y,
    input  logic [2:0]            px_color,
    input  logic                  fill_start,
    input  logic [XW-1:0]         fill_x0,
    input  logic [YW-1:0]         fill_y0,
    input  logic [XW:0]           fill_w,
    input  logic [YW:0]           fill_h,
    input  logic [2:0]            fill_color,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [2:0]            fb_data
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
    typedef enum logic {G_CPU, G_FILL} grant_t;

    localparam logic [XW:0]   FB_W_X  = (XW+1)'(FB_WIDTH);
    localparam logic [XW+1:0] FB_W_X2 = (XW+2)'(FB_WIDTH);
    localparam logic [YW:0]   FB_H_Y  = (YW+1)'(FB_HEIGHT);
    localparam logic [YW+1:0] FB_H_Y2 = (YW+2)'(FB_HEIGHT);

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [XW-1:0] x,
                                                        input logic [YW-1:0] y);
        return ADDR_WIDTH'(32'(y) * 32'(FB_WIDTH) + 32'(x));
    endfunction

    state_t                  state_q, state_d;
    grant_t                  last_grant_q, last_grant_d;
    logic [XW-1:0]           x0_q, x0_d;
    logic [XW-1:0]           cx_q, cx_d;
    logic [YW-1:0]           cy_q, cy_d;
    logic [XW:0]             x_end_q, x_end_d;
    logic [YW:0]             y_end_q, y_end_d;
    logic [2:0]              color_q, color_d;
    logic                    fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0]   fb_addr_q, fb_addr_d;
    logic [2:0]              fb_data_q, fb_data_d;
    logic                    fill_busy_q, fill_busy_d;
    logic                    fill_done_q, fill_done_d;

    logic                    cpu_req, fill_req, contested;
    logic                    grant_cpu, grant_fill;
    logic                    px_in_range, fill_empty;
    logic                    last_col, last_row;
    logic [XW+1:0]           x_sum;
    logic [YW+1:0]           y_sum;

    always_comb begin
        cpu_req    = px_valid;
        fill_req   = (state_q == S_FILL);
        contested  = cpu_req && fill_req;
        // On contention the side that lost the previous contest wins this one.
        grant_cpu  = cpu_req && (!fill_req || last_grant_q == G_FILL);
        grant_fill = fill_req && (!cpu_req || last_grant_q == G_CPU);

        px_in_range = ({1'b0, px_x} < FB_W_X) && ({1'b0, px_y} < FB_H_Y);
        last_col    = ({1'b0, cx_q} == x_end_q - (XW+1)'(1));
        last_row    = ({1'b0, cy_q} == y_end_q - (YW+1)'(1));

        x_sum = {2'b00, fill_x0} + {1'b0, fill_w};
        y_sum = {2'b00, fill_y0} + {1'b0, fill_h};
        fill_empty = (fill_w == '0) || (fill_h == '0) ||
                     ({1'b0, fill_x0} >= FB_W_X) || ({1'b0, fill_y0} >= FB_H_Y);

        state_d      = state_q;
        last_grant_d = last_grant_q;
        x0_d         = x0_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        x_end_d      = x_end_q;
        y_end_d      = y_end_q;
        color_d      = color_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;

        if (contested) begin
            last_grant_d = grant_cpu ? G_CPU : G_FILL;
        end

        // An off-screen CPU pixel still consumes its slot but writes nothing.
        if (grant_cpu) begin
            if (px_in_range) begin
                fb_we_d   = 1'b1;
                fb_addr_d = cell_addr(px_x, px_y);
                fb_data_d = px_color;
            end
        end else if (grant_fill) begin
            fb_we_d   = 1'b1;
            fb_addr_d = cell_addr(cx_q, cy_q);
            fb_data_d = color_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    x0_d    = fill_x0;
                    cx_d    = fill_x0;
                    cy_d    = fill_y0;
                    color_d = fill_color;
                    x_end_d = (x_sum > FB_W_X2) ? FB_W_X : x_sum[XW:0];
                    y_end_d = (y_sum > FB_H_Y2) ? FB_H_Y : y_sum[YW:0];
                    state_d = fill_empty ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (grant_fill) begin
                    if (last_col) begin
                        cx_d = x0_q;
                        cy_d = cy_q + YW'(1);
                        if (last_row) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fill_busy_d = (state_d != S_IDLE);
        fill_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= G_FILL;
            x0_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            x_end_q      <= '0;
            y_end_q      <= '0;
            color_q      <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            x0_q         <= x0_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_end_q      <= x_end_d;
            y_end_q      <= y_end_d;
            color_q      <= color_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fill_busy_q  <= fill_busy_d;
            fill_done_q  <= fill_done_d;
        end
    end

    assign px_ready  = grant_cpu;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;

endmodule
